// File: rtl/traffic_sensor_conditioner_if.sv
`default_nettype none
// ============================================================================
// Interface : traffic_sensor_conditioner_if
// Brief     : Raw sensor/button inputs and the conditioned Ta/Tb/P/R/conflict
//             outputs of the intersection front end.
// Revision  : 1.0 - initial release
// ============================================================================
interface traffic_sensor_conditioner_if;
    // Raw, asynchronous, possibly bouncing inputs
    logic car_a_raw;
    logic car_b_raw;
    logic parade_raw;
    logic release_raw;

    // Conditioned, registered outputs
    logic Ta;
    logic Tb;
    logic P;
    logic R;
    logic conflict;

    // Side that supplies the raw inputs and consumes the conditioned outputs
    modport master (
        output car_a_raw,
        output car_b_raw,
        output parade_raw,
        output release_raw,
        input  Ta,
        input  Tb,
        input  P,
        input  R,
        input  conflict
    );

    // The conditioner itself
    modport slave (
        input  car_a_raw,
        input  car_b_raw,
        input  parade_raw,
        input  release_raw,
        output Ta,
        output Tb,
        output P,
        output R,
        output conflict
    );
endinterface
`default_nettype wire

// File: rtl/traffic_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : traffic_sensor_conditioner
// Brief    : Synchronises and debounces the street A/B car sensors and the
//            parade/release buttons. Car channels produce level outputs with a
//            post-departure hold time; buttons produce single-cycle pulses with
//            conflict detection when both rise together.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_sensor_conditioner #(
    parameter int DEB_CYCLES  = 4,   // stable cycles before a debounced value changes
    parameter int HOLD_CYCLES = 8,   // cycles Ta/Tb stay high after the car leaves
    parameter int CW          = 4    // debounce/hold counter width
) (
    input wire clk,
    input wire rst,                  // asynchronous, active-low
    traffic_sensor_conditioner_if.slave bus
);

    // Channel order used throughout: 0 = car A, 1 = car B, 2 = parade, 3 = release
    localparam int             c_nch      = 4;
    localparam logic [CW-1:0]  c_deb_last = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0]  c_hold     = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0]  c_one      = CW'(1);

    logic [c_nch-1:0] w_raw;
    logic [c_nch-1:0] r_sync1;
    logic [c_nch-1:0] r_sync2;
    logic [c_nch-1:0] w_db;        // debounced value per channel
    logic [c_nch-1:0] w_chg;       // debounced value flips on this edge
    logic [c_nch-1:0] w_rise;
    logic [c_nch-1:0] w_fall;
    logic [1:0]       w_hold_act;  // car hold timers still running
    logic [1:0]       r_btn_d;     // debounced buttons, one edge old
    logic             w_p_rise;
    logic             w_r_rise;
    logic             r_ta;
    logic             r_tb;
    logic             r_p;
    logic             r_r;
    logic             r_conflict;

    assign w_raw = {bus.release_raw, bus.parade_raw, bus.car_b_raw, bus.car_a_raw};

    // Two-flop synchroniser for every raw input; only the second stage is used
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Per-channel debouncer: the synchronised value must disagree with the
    // debounced value for DEB_CYCLES consecutive edges before it is accepted.
    for (genvar i = 0; i < c_nch; i++) begin : g_deb
        logic          r_db;
        logic [CW-1:0] r_cnt;

        // Count consecutive disagreements; any agreement restarts the count
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_db  <= 1'b0;
                r_cnt <= '0;
            end else if (r_sync2[i] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt >= c_deb_last) begin
                r_db  <= r_sync2[i];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_one;
            end
        end

        assign w_db[i]   = r_db;
        assign w_chg[i]  = (r_sync2[i] != r_db) && (r_cnt >= c_deb_last);
        assign w_rise[i] = w_chg[i] & ~r_db;
        assign w_fall[i] = w_chg[i] &  r_db;
    end

    // Post-departure hold timers for the two car channels. The timer is loaded
    // on the same edge the debounced value falls so Ta/Tb never dip to 0.
    for (genvar i = 0; i < 2; i++) begin : g_hold
        logic [CW-1:0] r_hold;

        // Load on departure, clear on arrival, otherwise count down to zero
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_hold <= '0;
            end else if (w_fall[i]) begin
                r_hold <= c_hold;
            end else if (w_rise[i]) begin
                r_hold <= '0;
            end else if (r_hold != '0) begin
                r_hold <= r_hold - c_one;
            end
        end

        assign w_hold_act[i] = (r_hold != '0);
    end

    // Button edges are taken from the debounced value against its one-edge-old
    // copy, so a held button yields exactly one rise.
    assign w_p_rise = w_db[2] & ~r_btn_d[0];
    assign w_r_rise = w_db[3] & ~r_btn_d[1];

    // Registered outputs: traffic levels, mutually exclusive pulses, conflict
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_d    <= '0;
            r_ta       <= 1'b0;
            r_tb       <= 1'b0;
            r_p        <= 1'b0;
            r_r        <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_btn_d    <= w_db[3:2];
            r_ta       <= w_db[0] | w_hold_act[0];
            r_tb       <= w_db[1] | w_hold_act[1];
            r_p        <= w_p_rise & ~w_r_rise;
            r_r        <= w_r_rise & ~w_p_rise;
            r_conflict <= w_p_rise &  w_r_rise;
        end
    end

    assign bus.Ta       = r_ta;
    assign bus.Tb       = r_tb;
    assign bus.P        = r_p;
    assign bus.R        = r_r;
    assign bus.conflict = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_traffic_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_sensor_conditioner
// Brief    : Self-checking bench for traffic_sensor_conditioner: directed table,
//            hand-written corner sequences and random stimulus against a
//            window-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_sensor_conditioner;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int HD   = 16;   // model history depth

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    traffic_sensor_conditioner_if bus ();

    traffic_sensor_conditioner #(
        .DEB_CYCLES (DEB),
        .HOLD_CYCLES(HOLD),
        .CW         (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ------------------------------------------------------------------
    // Reference model. Bit order {release, parade, car_b, car_a}.
    // m_raw[j] : raw sample taken j edges ago (0 = this edge)
    // m_db[j]  : debounced value after the edge j edges ago
    // A debounced value flips when the DEB raw samples that reach the
    // second synchroniser stage in the last DEB edges all disagree with it.
    // Ta/Tb: any debounced 1 within the last HOLD+1 edges, one edge late.
    // Pulses: debounced 0->1 of the previous edge, registered.
    // ------------------------------------------------------------------
    logic [3:0] m_raw [HD];
    logic [3:0] m_db  [HD];
    logic [4:0] m_out;          // {Ta, Tb, P, R, conflict}

    task automatic model_clear();
        for (int j = 0; j < HD; j++) begin
            m_raw[j] = '0;
            m_db[j]  = '0;
        end
        m_out = '0;
    endtask

    task automatic model_edge(input logic [3:0] raw);
        logic [3:0] nd;
        logic       flip;
        logic       ta, tb, pr, rr;
        for (int j = HD - 1; j > 0; j--) m_raw[j] = m_raw[j-1];
        m_raw[0] = raw;
        for (int c = 0; c < 4; c++) begin
            flip = 1'b1;
            for (int j = 2; j <= DEB + 1; j++)
                if (m_raw[j][c] == m_db[0][c]) flip = 1'b0;
            nd[c] = flip ? ~m_db[0][c] : m_db[0][c];
        end
        for (int j = HD - 1; j > 0; j--) m_db[j] = m_db[j-1];
        m_db[0] = nd;
        ta = 1'b0;
        tb = 1'b0;
        for (int j = 1; j <= HOLD + 1; j++) begin
            ta = ta | m_db[j][0];
            tb = tb | m_db[j][1];
        end
        pr    = m_db[1][2] & ~m_db[2][2];
        rr    = m_db[1][3] & ~m_db[2][3];
        m_out = {ta, tb, pr & ~rr, rr & ~pr, pr & rr};
    endtask

    // ------------------------------------------------------------------
    // Checking and driving helpers
    // ------------------------------------------------------------------
    function automatic logic [4:0] outs();
        return {bus.Ta, bus.Tb, bus.P, bus.R, bus.conflict};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got {Ta,Tb,P,R,conflict}=%b, expected %b", name, $time, act, exp);
        end
    endtask

    // Drive raw inputs, advance one edge, update model, sample 1 time unit later
    task automatic step(input logic [3:0] raw);
        bus.car_a_raw   = raw[0];
        bus.car_b_raw   = raw[1];
        bus.parade_raw  = raw[2];
        bus.release_raw = raw[3];
        @(posedge clk);
        if (!rst) model_clear();
        else      model_edge(raw);
        #1;
        check("model", outs(), m_out);
    endtask

    // ------------------------------------------------------------------
    // Directed table
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0] raw;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] raw, input logic [4:0] exp);
        vec_t v;
        v.raw = raw;
        v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic build_table();
        // Car A arrives: Ta rises 6 edges after the first sample, then the
        // car leaves: db falls 5 edges after the first 0 sample, Ta 9 later.
        for (int k = 0; k < 8; k++)  add(4'b0001, (k >= 6) ? 5'b10000 : 5'b00000);
        for (int k = 8; k < 24; k++) add(4'b0000, (k <= 21) ? 5'b10000 : 5'b00000);
        // Glitches of 1, 2 and 3 cycles never reach Ta
        for (int w = 1; w <= 3; w++) begin
            for (int k = 0; k < w; k++) add(4'b0001, 5'b00000);
            for (int k = 0; k < 6; k++) add(4'b0000, 5'b00000);
        end
        // A 4-cycle pulse is accepted; Ta high for rel. edges 6..17
        for (int k = 0; k < 20; k++)
            add((k < 4) ? 4'b0001 : 4'b0000, (k >= 6 && k <= 17) ? 5'b10000 : 5'b00000);
        // Parade bounce 1,0,1 then held: one P pulse, 8 edges after first sample
        for (int k = 0; k < 23; k++)
            add((k == 1) ? 4'b0000 : 4'b0100, (k == 8) ? 5'b00100 : 5'b00000);
        // Button release produces nothing
        for (int k = 0; k < 12; k++) add(4'b0000, 5'b00000);
        // Parade and release together: conflict only
        for (int k = 0; k < 10; k++) add(4'b1100, (k == 6) ? 5'b00001 : 5'b00000);
        for (int k = 0; k < 12; k++) add(4'b0000, 5'b00000);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [3:0] rr;
        int         flip_range;

        bus.car_a_raw   = 1'b0;
        bus.car_b_raw   = 1'b0;
        bus.parade_raw  = 1'b0;
        bus.release_raw = 1'b0;
        model_clear();
        rst = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", outs(), 5'b00000);
        rst = 1'b1;

        // Directed table
        build_table();
        foreach (tbl[i]) begin
            step(tbl[i].raw);
            check("table", outs(), tbl[i].exp);
        end

        // Car B leaves for 6 cycles and returns during hold: Tb never drops
        for (int k = 0; k < 10; k++) step(4'b0010);
        check("tb_present", {1'b0, bus.Tb, 3'b000}, 5'b01000);
        for (int k = 0; k < 20; k++) begin
            step((k < 6) ? 4'b0000 : 4'b0010);
            check("tb_no_gap", {1'b0, bus.Tb, 3'b000}, 5'b01000);
        end
        for (int k = 0; k < 16; k++) step(4'b0000);

        // Mid-run asynchronous reset with Ta high and P pulsing
        for (int k = 0; k < 7; k++) step(4'b0101);
        check("pre_reset", outs(), 5'b10100);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", outs(), 5'b00000);
        for (int k = 0; k < 2; k++) step(4'b0101);
        rst = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step(4'b0101);
            check("reset_latency", outs(), (k == 6) ? 5'b10100 : 5'b00000);
        end
        for (int k = 0; k < 16; k++) step(4'b0000);

        // Random stimulus: alternating calm and bouncy segments, rare resets
        rr = '0;
        for (int k = 0; k < 3000; k++) begin
            flip_range = ((k / 100) % 2 == 1) ? 1 : 9;
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, flip_range) == 0) rr[c] = ~rr[c];
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b0;
                #1;
                check("rand_async_reset", outs(), 5'b00000);
                step(rr);
                rst = 1'b1;
            end else begin
                step(rr);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
